emu_ram_scan_ctrl: RTL and testbench

//  Parametrised scan controller that dumps or restores one target memory through a

---
 rtl/emu_ram_scan_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_emu_ram_scan_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emu_ram_scan_ctrl.sv
// ---------------------------------------------------------------------------
// emu_ram_scan_ctrl
//
// Dumps or restores one target memory through a SCAN_WIDTH-bit checkpoint
// port. Each DATA_WIDTH-bit memory word travels as BEATS beats, with beat k
// carrying word bits [k*SCAN_WIDTH +: SCAN_WIDTH]. On dump the last beat is
// zero-padded. On load the pad bits are dropped.
//
// Ports
//   host_clk, host_rst_n  clock, asynchronous active-low reset
//   scan_mode             1 = scan port live; 0 = inputs ignored, state frozen
//   ram_sr                restart: clears counters and buffers, latches ram_sd
//   ram_se                beat strobe (one beat per high cycle)
//   ram_sd                direction sampled at restart: 0 dump, 1 load
//   ram_di / ram_do       load beat in / dump beat out
//   ram_do_valid          ram_do carries a dump beat
//   ram_done              all DEPTH words transferred since the last restart
//   mem_ren/raddr/rdata   memory read port (rdata one cycle after ren)
//   mem_wen/waddr/wdata   memory write port
// ---------------------------------------------------------------------------
module emu_ram_scan_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8,
  parameter int SCAN_WIDTH = 64,
  localparam int AW        = $clog2(DEPTH),
  localparam int BEATS     = (DATA_WIDTH + SCAN_WIDTH - 1) / SCAN_WIDTH
) (
  input  logic                  host_clk,
  input  logic                  host_rst_n,
  input  logic                  scan_mode,
  input  logic                  ram_sr,
  input  logic                  ram_se,
  input  logic                  ram_sd,
  input  logic [SCAN_WIDTH-1:0] ram_di,
  output logic [SCAN_WIDTH-1:0] ram_do,
  output logic                  ram_do_valid,
  output logic                  ram_done,
  output logic                  mem_ren,
  output logic [AW-1:0]         mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [AW-1:0]         mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW = BEATS * SCAN_WIDTH;   // word width padded to whole beats
  localparam int CW = AW + 1;               // must be able to hold DEPTH

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,   // after reset, waiting for a restart
    S_DUMP = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // Counters: word_cnt = words consumed (dump) / written (load);
  // xfer_cnt = reads issued (dump) / words assembled (load).
  logic [AW-1:0] word_cnt;
  logic [BW-1:0] beat_cnt;
  logic [CW-1:0] xfer_cnt;

  // Dump side: output word register plus one prefetch register.
  logic [DATA_WIDTH-1:0] out_word, pf_word;
  logic                  out_valid, pf_valid, rd_pending;
  logic [PW-1:0]         out_pad;

  // Load side: assembly register plus write holding register.
  logic [PW-1:0]         asm_reg, asm_full;
  logic [DATA_WIDTH-1:0] wbuf;
  logic                  wbuf_valid;

  logic active, restart;
  logic last_beat, last_word, xfer_left;
  logic dump_beat, dump_word, load_beat, load_word, write_word, issue_read;
  logic [1:0] occ;

  assign restart = scan_mode & ram_sr;
  assign active  = scan_mode & ~ram_sr;

  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign last_word = (word_cnt == AW'(DEPTH - 1));
  assign xfer_left = (xfer_cnt < CW'(DEPTH));

  // A strobe without a valid beat is a host error and is simply dropped.
  assign dump_beat  = active & ram_se & (state == S_DUMP) & out_valid;
  assign dump_word  = dump_beat & last_beat;
  assign load_beat  = active & ram_se & (state == S_LOAD) & xfer_left;
  assign load_word  = load_beat & last_beat;
  assign write_word = active & (state == S_LOAD) & wbuf_valid;

  // Slots occupied at the next edge if no read is issued now. A read may go
  // out only if its data is guaranteed a slot when it returns; counting the
  // word being consumed this cycle keeps BEATS=1 at one beat per cycle.
  assign occ = 2'(out_valid) + 2'(pf_valid) + 2'(rd_pending) - 2'(dump_word);
  assign issue_read = active & (state == S_DUMP) & xfer_left & (occ < 2'd2);

  assign out_pad = PW'(out_word);

  // Current assembly register with this cycle's beat merged in, so the last
  // beat can be forwarded straight into the write holding register.
  always_comb begin
    asm_full = asm_reg;
    asm_full[beat_cnt*SCAN_WIDTH +: SCAN_WIDTH] = ram_di;
  end

  if (PW > DATA_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^asm_full[PW-1:DATA_WIDTH];
  end

  // ---------------- state register ----------------
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) state <= S_IDLE;
    else             state <= state_next;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = ram_sd ? S_LOAD : S_DUMP;
    end else begin
      case (state)
        S_DUMP:  if (dump_word && last_word)  state_next = S_DONE;
        S_LOAD:  if (write_word && last_word) state_next = S_DONE;
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    mem_ren      = issue_read;
    mem_raddr    = issue_read ? xfer_cnt[AW-1:0] : '0;
    mem_wen      = write_word;
    mem_waddr    = write_word ? word_cnt : '0;
    mem_wdata    = wbuf;
    ram_done     = (state == S_DONE);
    ram_do_valid = out_valid & (state == S_DUMP);
    ram_do       = ram_do_valid ? out_pad[beat_cnt*SCAN_WIDTH +: SCAN_WIDTH] : '0;
  end

  // ---------------- datapath ----------------
  // Every enable is qualified by scan_mode, so with scan_mode=0 nothing moves
  // except a read already in flight, which must land in its reserved slot
  // because the memory presents its data for one cycle only.
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      word_cnt   <= '0;
      beat_cnt   <= '0;
      xfer_cnt   <= '0;
      out_word   <= '0;
      pf_word    <= '0;
      out_valid  <= 1'b0;
      pf_valid   <= 1'b0;
      rd_pending <= 1'b0;
      asm_reg    <= '0;
      wbuf       <= '0;
      wbuf_valid <= 1'b0;
    end else if (restart) begin
      // A read returning next cycle is discarded: rd_pending is cleared.
      word_cnt   <= '0;
      beat_cnt   <= '0;
      xfer_cnt   <= '0;
      out_word   <= '0;
      pf_word    <= '0;
      out_valid  <= 1'b0;
      pf_valid   <= 1'b0;
      rd_pending <= 1'b0;
      asm_reg    <= '0;
      wbuf       <= '0;
      wbuf_valid <= 1'b0;
    end else begin
      rd_pending <= issue_read;
      if (issue_read || load_word) xfer_cnt <= xfer_cnt + 1'b1;

      // Refill the output register from prefetch first (oldest word), then
      // from returning read data; otherwise park returning data in prefetch.
      if (!out_valid || dump_word) begin
        if (pf_valid) begin
          out_word  <= pf_word;
          out_valid <= 1'b1;
          pf_valid  <= rd_pending;
          if (rd_pending) pf_word <= mem_rdata;
        end else if (rd_pending) begin
          out_word  <= mem_rdata;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_pending) begin
        pf_word  <= mem_rdata;
        pf_valid <= 1'b1;
      end

      if (dump_beat || load_beat) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      // word_cnt saturates at DEPTH-1; the state machine records completion.
      if ((dump_word || write_word) && !last_word) word_cnt <= word_cnt + 1'b1;

      if (load_beat) asm_reg <= asm_full;
      if (load_word) begin
        wbuf       <= asm_full[DATA_WIDTH-1:0];
        wbuf_valid <= 1'b1;
      end else if (write_word) begin
        wbuf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_emu_ram_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_emu_ram_scan_ctrl
//
// Three controller instances share one clock and reset:
//   0: DATA_WIDTH=128, SCAN_WIDTH=64 (BEATS=2)
//   1: DATA_WIDTH=32,  SCAN_WIDTH=64 (BEATS=1)
//   2: DATA_WIDTH=100, SCAN_WIDTH=32 (BEATS=4)
// Each instance gets its own memory model, driven from the stimulus
// process. Expected beats come from shifting stored words, and expected
// memory contents come from concatenating beats.
// ---------------------------------------------------------------------------
module tb_emu_ram_scan_ctrl;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        scan_mode [NI];
  logic        sr [NI];
  logic        se [NI];
  logic        sd [NI];
  logic [63:0] di [NI];

  logic [63:0]  do_bus    [NI];
  logic         vld_bus   [NI];
  logic         done_bus  [NI];
  logic         ren_bus   [NI];
  logic         wen_bus   [NI];
  logic [2:0]   raddr_bus [NI];
  logic [2:0]   waddr_bus [NI];
  logic [127:0] wdata_bus [NI];
  logic [127:0] rdata_bus [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int DW = (gi == 0) ? 128 : (gi == 1) ? 32 : 100;
    localparam int SW = (gi == 2) ? 32 : 64;
    logic [SW-1:0] do_w;
    logic [DW-1:0] wdata_w;
    emu_ram_scan_ctrl #(.DATA_WIDTH(DW), .DEPTH(8), .SCAN_WIDTH(SW)) u_dut (
      .host_clk     (clk),
      .host_rst_n   (rst_n),
      .scan_mode    (scan_mode[gi]),
      .ram_sr       (sr[gi]),
      .ram_se       (se[gi]),
      .ram_sd       (sd[gi]),
      .ram_di       (di[gi][SW-1:0]),
      .ram_do       (do_w),
      .ram_do_valid (vld_bus[gi]),
      .ram_done     (done_bus[gi]),
      .mem_ren      (ren_bus[gi]),
      .mem_raddr    (raddr_bus[gi]),
      .mem_rdata    (rdata_bus[gi][DW-1:0]),
      .mem_wen      (wen_bus[gi]),
      .mem_waddr    (waddr_bus[gi]),
      .mem_wdata    (wdata_w)
    );
    assign do_bus[gi]    = 64'(do_w);
    assign wdata_bus[gi] = 128'(wdata_w);
  end

  // Memory models and per-cycle samples
  logic [127:0] mem [NI][8];
  logic [127:0] orig [8];
  logic         p_ren [NI];
  logic [2:0]   p_raddr [NI];
  int           wr_cnt [NI];
  logic [2:0]   wr_addr [NI][16];
  logic [63:0]  s_do [NI];
  logic         s_vld [NI];
  logic         s_done [NI];
  logic         s_wen [NI];
  logic [63:0]  capq [$];
  logic [63:0]  ldq [$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic int dw_of(input int k);
    return (k == 0) ? 128 : (k == 1) ? 32 : 100;
  endfunction

  function automatic int sw_of(input int k);
    return (k == 2) ? 32 : 64;
  endfunction

  function automatic int beats_of(input int k);
    return (dw_of(k) + sw_of(k) - 1) / sw_of(k);
  endfunction

  function automatic logic [127:0] dw_mask(input int k);
    logic [127:0] one = 128'd1;
    return (dw_of(k) >= 128) ? '1 : ((one << dw_of(k)) - 128'd1);
  endfunction

  // Beat b of a word: bits [b*SW +: SW], zero beyond the word.
  function automatic logic [63:0] beat_of(input logic [127:0] word, input int k, input int b);
    logic [127:0] t;
    logic [63:0]  m;
    logic [63:0]  one = 64'd1;
    t = (word & dw_mask(k)) >> (b * sw_of(k));
    m = (sw_of(k) == 64) ? '1 : ((one << sw_of(k)) - 64'd1);
    return t[63:0] & m;
  endfunction

  function automatic logic [127:0] rand_word(input int k);
    return {$urandom(), $urandom(), $urandom(), $urandom()} & dw_mask(k);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, memory responds just after
  // the rising edge (registered read, one cycle latency).
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      s_do[k]   = do_bus[k];
      s_vld[k]  = vld_bus[k];
      s_done[k] = done_bus[k];
      s_wen[k]  = wen_bus[k];
      if (wen_bus[k]) begin
        mem[k][waddr_bus[k]] = wdata_bus[k];
        if (wr_cnt[k] < 16) wr_addr[k][wr_cnt[k]] = waddr_bus[k];
        wr_cnt[k]++;
        $display("write inst=%0d addr=%0d data=%h", k, waddr_bus[k], wdata_bus[k]);
      end
      p_ren[k]   = ren_bus[k];
      p_raddr[k] = raddr_bus[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++)
      rdata_bus[k] = p_ren[k] ? mem[k][p_raddr[k]] : {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic restart(input int k, input logic dir);
    sr[k] = 1'b1;
    sd[k] = dir;
    se[k] = 1'b0;
    step();
    sr[k] = 1'b0;
    wr_cnt[k] = 0;
  endtask

  // Consume n dump beats with ram_se high pct% of cycles, checking each beat.
  task automatic dump_run(input int k, input int n, input int pct,
                          output int first_s, output int last_s);
    int got = 0;
    int t = 0;
    int bts = beats_of(k);
    first_s = -1;
    last_s  = -1;
    while (got < n && t < 400) begin
      se[k] = (int'($urandom_range(99)) < pct);
      step();
      t++;
      if (first_s < 0 && s_vld[k]) first_s = t;
      if (s_vld[k] && se[k]) begin
        chk($sformatf("dump%0d_beat%0d", k, got), 128'(s_do[k]),
            128'(beat_of(mem[k][got / bts], k, got % bts)));
        chk($sformatf("dump%0d_notdone%0d", k, got), 128'(s_done[k]), 128'd0);
        $display("dump inst=%0d beat=%0d data=%h", k, got, s_do[k]);
        capq.push_back(s_do[k]);
        last_s = t;
        got++;
      end
    end
    se[k] = 1'b0;
    if (got < n) chk($sformatf("dump%0d_timeout", k), 128'(got), 128'(n));
  endtask

  // Feed ldq as load beats; optionally freeze scan_mode for 3 cycles once
  // freeze_at beats have gone in. Then wait for completion and check writes.
  task automatic load_run(input int k, input int pct, input int freeze_at);
    int idx = 0;
    int t = 0;
    bit froze = 1'b0;
    int n = ldq.size();
    while (idx < n && t < 400) begin
      if (idx == freeze_at && !froze) begin
        froze = 1'b1;
        scan_mode[k] = 1'b0;
        for (int c = 0; c < 3; c++) begin
          se[k] = 1'b1;
          di[k] = {$urandom(), $urandom()};
          step();
          chk($sformatf("freeze%0d_wen%0d", k, c), 128'(s_wen[k]), 128'd0);
        end
        scan_mode[k] = 1'b1;
      end
      se[k] = (int'($urandom_range(99)) < pct);
      di[k] = se[k] ? ldq[idx] : {$urandom(), $urandom()};
      step();
      t++;
      if (se[k]) idx++;
    end
    se[k] = 1'b0;
    if (idx < n) chk($sformatf("load%0d_timeout", k), 128'(idx), 128'(n));
    t = 0;
    s_done[k] = 1'b0;
    while (!s_done[k] && t < 20) begin
      step();
      t++;
    end
    chk($sformatf("load%0d_done", k), 128'(s_done[k]), 128'd1);
    chk($sformatf("load%0d_nwrites", k), 128'(wr_cnt[k]), 128'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("load%0d_waddr%0d", k, i), 128'(wr_addr[k][i]), 128'(i));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, l;
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      scan_mode[k] = 1'b0; sr[k] = 1'b0; se[k] = 1'b0; sd[k] = 1'b0;
      di[k] = '0; rdata_bus[k] = '0; wr_cnt[k] = 0;
      for (int i = 0; i < 8; i++) mem[k][i] = '0;
    end

    // ---- reset state ----
    step();
    step();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst%0d_do", k), 128'(s_do[k]), 128'd0);
      chk($sformatf("rst%0d_vld", k), 128'(s_vld[k]), 128'd0);
      chk($sformatf("rst%0d_done", k), 128'(s_done[k]), 128'd0);
      chk($sformatf("rst%0d_ren", k), 128'(p_ren[k]), 128'd0);
      chk($sformatf("rst%0d_wen", k), 128'(s_wen[k]), 128'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) scan_mode[k] = 1'b1;
    step();

    // ---- T1: full-rate dump, 128/64 ----
    for (int i = 0; i < 8; i++) mem[0][i] = {4{32'hA0 + 32'(i)}};
    restart(0, 1'b0);
    dump_run(0, 16, 100, f, l);
    chk("t1_first_valid_le3", 128'((f > 0) && (f <= 3)), 128'd1);
    chk("t1_throughput", 128'(l - f), 128'd15);
    se[0] = 1'b1;
    step();
    chk("t1_done", 128'(s_done[0]), 128'd1);
    chk("t1_vld_after", 128'(s_vld[0]), 128'd0);
    chk("t1_do_after", 128'(s_do[0]), 128'd0);
    step();
    chk("t1_no_read_after_done", 128'(p_ren[0]), 128'd0);
    chk("t1_done_sticky", 128'(s_done[0]), 128'd1);
    se[0] = 1'b0;

    // ---- T2: load with 50% strobe, 32/64 ----
    ldq.delete();
    for (int i = 0; i < 8; i++) ldq.push_back(64'(i) * 64'h1111);
    restart(1, 1'b1);
    load_run(1, 50, -1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_mem%0d", i), mem[1][i], 128'(32'h1111 * 32'(i)));

    // ---- T3: narrow scan 100/32, dump then load round trip ----
    for (int i = 0; i < 8; i++) begin
      mem[2][i] = rand_word(2);
      orig[i] = mem[2][i];
    end
    capq.delete();
    restart(2, 1'b0);
    dump_run(2, 32, 60, f, l);
    step();
    chk("t3_dump_done", 128'(s_done[2]), 128'd1);
    for (int w = 0; w < 8; w++)
      chk($sformatf("t3_pad%0d", w), 128'(capq[w * 4 + 3] >> 4), 128'd0);
    for (int i = 0; i < 8; i++) mem[2][i] = '0;
    ldq.delete();
    foreach (capq[i]) ldq.push_back(capq[i]);
    restart(2, 1'b1);
    load_run(2, 50, -1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_roundtrip%0d", i), mem[2][i], orig[i]);

    // ---- T4: abort after 5 of 16 dump beats ----
    for (int i = 0; i < 8; i++) mem[0][i] = rand_word(0);
    restart(0, 1'b0);
    dump_run(0, 5, 100, f, l);
    restart(0, 1'b0);
    dump_run(0, 16, 50, f, l);
    step();
    chk("t4_done", 128'(s_done[0]), 128'd1);

    // ---- T5: freeze mid-load ----
    ldq.delete();
    for (int i = 0; i < 16; i++) ldq.push_back({$urandom(), $urandom()});
    restart(0, 1'b1);
    load_run(0, 100, 6);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t5_mem%0d", i), mem[0][i], {ldq[2 * i + 1], ldq[2 * i]});

    // ---- T6: asynchronous reset mid-dump ----
    for (int i = 0; i < 8; i++) mem[0][i] = rand_word(0);
    restart(0, 1'b0);
    dump_run(0, 3, 100, f, l);
    se[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_do", 128'(do_bus[0]), 128'd0);
    chk("t6_vld", 128'(vld_bus[0]), 128'd0);
    chk("t6_done", 128'(done_bus[0]), 128'd0);
    chk("t6_ren", 128'(ren_bus[0]), 128'd0);
    chk("t6_raddr", 128'(raddr_bus[0]), 128'd0);
    chk("t6_wen", 128'(wen_bus[0]), 128'd0);
    chk("t6_waddr", 128'(waddr_bus[0]), 128'd0);
    chk("t6_wdata", wdata_bus[0], 128'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_idle_done", 128'(s_done[0]), 128'd0);
    chk("t6_idle_vld", 128'(s_vld[0]), 128'd0);
    se[0] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
